// File: rtl/sram_array_1r1w_pkg.sv
// Shared types and helpers for the 1R1W masked memory array.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sram_array_pkg;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   // Upper bounds for mask_merge operands. Callers zero-pad to these widths
   // and take the low DATA_WIDTH bits. DATA_WIDTH must stay below
   // MAX_DATA_WIDTH and MASK_WIDTH below MAX_MASK_WIDTH.
   localparam int MAX_DATA_WIDTH = 512;
   localparam int MAX_MASK_WIDTH = 64;

   // Address width for a given depth, never narrower than one bit.
   function automatic int addr_width(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

   // Replace every group of old_data whose mask bit is set with the same
   // group of new_data. Group g covers bits [(g+1)*group_width-1 : g*group_width].
   function automatic logic [MAX_DATA_WIDTH-1:0] mask_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_data,
      input logic [MAX_DATA_WIDTH-1:0] new_data,
      input logic [MAX_MASK_WIDTH-1:0] mask,
      input int                        group_width
   );
      logic [MAX_DATA_WIDTH-1:0] result;
      result = old_data;
      for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
         if ((i / group_width) < MAX_MASK_WIDTH) begin
            if (mask[i / group_width]) begin
               result[i] = new_data[i];
            end
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/sram_array_1r1w_if.sv
// Request/response bundle for the 1R1W array: write port, read port, ready flag.
// Latency: n/a (signal bundle).
// Backpressure: none; init_done gates acceptance, nothing else stalls.
// master: drives w_*/r_en/r_addr, receives r_data/r_valid/init_done.
// slave:  the array side.
interface sram_array_1r1w_if #(
   parameter int DATA_WIDTH = 24,
   parameter int MASK_WIDTH = 4,
   parameter int DEPTH      = 256
);
   import sram_array_pkg::*;

   localparam int ADDR_WIDTH = addr_width(DEPTH);

   logic                  w_en;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [MASK_WIDTH-1:0] w_mask;
   logic                  r_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  init_done;

   modport master (
      output w_en, w_addr, w_data, w_mask, r_en, r_addr,
      input  r_data, r_valid, init_done
   );

   modport slave (
      input  w_en, w_addr, w_data, w_mask, r_en, r_addr,
      output r_data, r_valid, init_done
   );

endinterface

// File: rtl/sram_array_1r1w.sv
// Single-clock 1R1W array with per-group write masks, optional write->read
// forwarding and optional clear-after-reset sequencing.
// Latency: read and write 1 cycle. Backpressure: none once init_done is high;
// requests are ignored while init_done is low.
// Ports: clock, reset (async, active-high), bus (slave side of sram_array_1r1w_if).
module sram_array_1r1w
   import sram_array_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 24,
   parameter int                    DEPTH         = 256,
   parameter int                    MASK_WIDTH    = 4,
   parameter bit                    BYPASS        = 1'b1,
   parameter bit                    INIT_ON_RESET = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
   input  logic              clock,
   input  logic              reset,
   sram_array_1r1w_if.slave  bus
);

   localparam int ADDR_WIDTH  = addr_width(DEPTH);
   localparam int GROUP_WIDTH = DATA_WIDTH / MASK_WIDTH;
   localparam int PAD_D       = MAX_DATA_WIDTH - DATA_WIDTH;
   localparam int PAD_M       = MAX_MASK_WIDTH - MASK_WIDTH;
   localparam int LAST_INT    = DEPTH - 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = LAST_INT[ADDR_WIDTH-1:0];

   logic [DATA_WIDTH-1:0] ram [DEPTH];

   state_t                state;
   logic [ADDR_WIDTH-1:0] cnt;

   logic                  w_in_range;
   logic                  r_in_range;

   // Range checks only exist when the address space has holes.
   generate
      if (DEPTH != 2**ADDR_WIDTH) begin : g_range
         localparam logic [ADDR_WIDTH:0] DEPTH_EXT = DEPTH[ADDR_WIDTH:0];
         assign w_in_range = {1'b0, bus.w_addr} < DEPTH_EXT;
         assign r_in_range = {1'b0, bus.r_addr} < DEPTH_EXT;
      end else begin : g_full
         assign w_in_range = 1'b1;
         assign r_in_range = 1'b1;
      end
   endgenerate

   // Write port: the init sequencer owns it during INIT, the bus during RUN.
   logic                  wr_fire;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [MASK_WIDTH-1:0] wr_mask;

   always_comb begin
      wr_fire = 1'b0;
      wr_addr = bus.w_addr;
      wr_data = bus.w_data;
      wr_mask = bus.w_mask;
      if (state == INIT) begin
         wr_addr = cnt;
         wr_data = INIT_VALUE;
         wr_mask = '1;
         wr_fire = INIT_ON_RESET && !reset;
      end else begin
         wr_fire = bus.w_en && w_in_range;
      end
   end

   logic [MAX_DATA_WIDTH-1:0] wr_merged_full;
   logic [MAX_DATA_WIDTH-1:0] byp_merged_full;
   logic [2*PAD_D-1:0]        unused_merge_hi;

   assign wr_merged_full  = mask_merge({{PAD_D{1'b0}}, ram[wr_addr]},
                                       {{PAD_D{1'b0}}, wr_data},
                                       {{PAD_M{1'b0}}, wr_mask}, GROUP_WIDTH);
   // Forwarded value for a same-cycle write to the address being read.
   assign byp_merged_full = mask_merge({{PAD_D{1'b0}}, ram[bus.r_addr]},
                                       {{PAD_D{1'b0}}, bus.w_data},
                                       {{PAD_M{1'b0}}, bus.w_mask}, GROUP_WIDTH);
   assign unused_merge_hi = {wr_merged_full[MAX_DATA_WIDTH-1:DATA_WIDTH],
                             byp_merged_full[MAX_DATA_WIDTH-1:DATA_WIDTH]};

   logic                  collision;
   logic [DATA_WIDTH-1:0] rd_value;

   always_comb begin
      collision = bus.w_en && w_in_range && (bus.w_addr == bus.r_addr);
      rd_value  = '0;
      if (r_in_range) begin
         rd_value = (BYPASS && collision) ? byp_merged_full[DATA_WIDTH-1:0]
                                          : ram[bus.r_addr];
      end
   end

   // Storage carries no reset so it maps onto a memory macro.
   always_ff @(posedge clock) begin
      if (wr_fire) begin
         ram[wr_addr] <= wr_merged_full[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= INIT;
         cnt           <= '0;
         bus.r_data    <= '0;
         bus.r_valid   <= 1'b0;
         bus.init_done <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               bus.r_valid <= 1'b0;
               if (!INIT_ON_RESET || cnt == LAST_ENTRY) begin
                  state         <= RUN;
                  bus.init_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               bus.r_valid <= bus.r_en;
               if (bus.r_en) begin
                  bus.r_data <= rd_value;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_array_1r1w.sv
module tb_sram_array_1r1w;

   localparam int NI = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic        w_en, r_en;
   logic [7:0]  w_addr, r_addr;
   logic [23:0] w_data;
   logic [3:0]  w_mask;

   // Instance 0: defaults. Instance 1: BYPASS=0. Instance 2: DEPTH=200.
   sram_array_1r1w_if #(.DATA_WIDTH(24), .MASK_WIDTH(4), .DEPTH(256)) if0 ();
   sram_array_1r1w_if #(.DATA_WIDTH(24), .MASK_WIDTH(4), .DEPTH(256)) if1 ();
   sram_array_1r1w_if #(.DATA_WIDTH(24), .MASK_WIDTH(4), .DEPTH(200)) if2 ();

   assign if0.w_en = w_en, if0.w_addr = w_addr, if0.w_data = w_data,
          if0.w_mask = w_mask, if0.r_en = r_en, if0.r_addr = r_addr;
   assign if1.w_en = w_en, if1.w_addr = w_addr, if1.w_data = w_data,
          if1.w_mask = w_mask, if1.r_en = r_en, if1.r_addr = r_addr;
   assign if2.w_en = w_en, if2.w_addr = w_addr, if2.w_data = w_data,
          if2.w_mask = w_mask, if2.r_en = r_en, if2.r_addr = r_addr;

   sram_array_1r1w #(.DATA_WIDTH(24), .DEPTH(256), .MASK_WIDTH(4), .BYPASS(1'b1),
                     .INIT_ON_RESET(1'b1), .INIT_VALUE(24'h0))
      u_dut0 (.clock(clock), .reset(reset), .bus(if0));
   sram_array_1r1w #(.DATA_WIDTH(24), .DEPTH(256), .MASK_WIDTH(4), .BYPASS(1'b0),
                     .INIT_ON_RESET(1'b1), .INIT_VALUE(24'h0))
      u_dut1 (.clock(clock), .reset(reset), .bus(if1));
   sram_array_1r1w #(.DATA_WIDTH(24), .DEPTH(200), .MASK_WIDTH(4), .BYPASS(1'b1),
                     .INIT_ON_RESET(1'b1), .INIT_VALUE(24'h0))
      u_dut2 (.clock(clock), .reset(reset), .bus(if2));

   logic [23:0] got_rd [NI];
   logic        got_rv [NI];
   logic        got_done [NI];
   assign got_rd[0] = if0.r_data;  assign got_rv[0] = if0.r_valid;  assign got_done[0] = if0.init_done;
   assign got_rd[1] = if1.r_data;  assign got_rv[1] = if1.r_valid;  assign got_done[1] = if1.init_done;
   assign got_rd[2] = if2.r_data;  assign got_rv[2] = if2.r_valid;  assign got_done[2] = if2.init_done;

   // Reference model: plain arrays updated by the rules of the array.
   int          depth_of [NI] = '{256, 256, 200};
   bit          byp_of   [NI] = '{1'b1, 1'b0, 1'b1};
   logic [23:0] mdl_mem  [NI][256];
   logic [23:0] exp_rd   [NI];
   bit          exp_rv   [NI];
   bit          exp_done [NI];
   int          edge_n   [NI];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [23:0] merge(input logic [23:0] old_v, input logic [23:0] new_v,
                                         input logic [3:0] mask);
      logic [23:0] m;
      for (int b = 0; b < 24; b++) m[b] = mask[b / 6];
      return (old_v & ~m) | (new_v & m);
   endfunction

   // Apply one clock edge to the model using the currently driven inputs.
   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         if (edge_n[i] < depth_of[i]) begin
            mdl_mem[i][edge_n[i]] = 24'h0;
            exp_rv[i]   = 1'b0;
            exp_done[i] = (edge_n[i] == depth_of[i] - 1);
            edge_n[i]++;
         end else begin
            exp_done[i] = 1'b1;
            exp_rv[i]   = r_en;
            if (r_en) begin
               if (r_addr >= depth_of[i])
                  exp_rd[i] = 24'h0;
               else if (byp_of[i] && w_en && w_addr == r_addr)
                  exp_rd[i] = merge(mdl_mem[i][r_addr], w_data, w_mask);
               else
                  exp_rd[i] = mdl_mem[i][r_addr];
            end
            if (w_en && w_addr < depth_of[i])
               mdl_mem[i][w_addr] = merge(mdl_mem[i][w_addr], w_data, w_mask);
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("r_valid[%0d]", i), got_rv[i], exp_rv[i]);
         check($sformatf("init_done[%0d]", i), got_done[i], exp_done[i]);
         check($sformatf("r_data[%0d]", i), got_rd[i], exp_rd[i]);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic hold_reset(input int ncyc);
      reset = 1'b1;
      for (int i = 0; i < NI; i++) begin
         edge_n[i] = 0; exp_rv[i] = 1'b0; exp_rd[i] = 24'h0; exp_done[i] = 1'b0;
      end
      #1;
      check_all();
      repeat (ncyc) begin
         @(posedge clock);
         #1;
         check_all();
      end
      reset = 1'b0;
   endtask

   task automatic set_idle();
      w_en = 1'b0; r_en = 1'b0; w_addr = 8'h0; r_addr = 8'h0; w_data = 24'h0; w_mask = 4'h0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [23:0] d, input logic [3:0] m);
      set_idle(); w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
      tick();
   endtask

   task automatic rd(input logic [7:0] a);
      set_idle(); r_en = 1'b1; r_addr = a;
      tick();
   endtask

   function automatic logic [7:0] pick_addr();
      case ($urandom_range(0, 2))
         0:       return 8'($urandom_range(0, 7));
         1:       return 8'($urandom_range(190, 215));
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic rand_inputs();
      w_en   = 1'($urandom_range(0, 1));
      r_en   = 1'($urandom_range(0, 1));
      w_addr = pick_addr();
      r_addr = ($urandom_range(0, 3) == 0) ? w_addr : pick_addr();
      w_data = 24'($urandom);
      w_mask = 4'($urandom);
   endtask

   initial begin
      set_idle();
      #2;
      hold_reset(3);

      // Initial clear with random requests that must all be ignored.
      repeat (256) begin
         rand_inputs();
         tick();
      end
      check("init_done_after_255", got_done[0], 1'b1);

      rd(8'h7F);
      check("rd_7f_data", got_rd[0], 24'h000000);
      check("rd_7f_valid", got_rv[0], 1'b1);

      wr(8'h10, 24'hABCDEF, 4'hF);
      rd(8'h10);
      check("full_write", got_rd[0], 24'hABCDEF);
      repeat (3) begin
         set_idle();
         tick();
         check("hold_data", got_rd[0], 24'hABCDEF);
         check("hold_valid", got_rv[0], 1'b0);
      end

      wr(8'h10, 24'h000000, 4'h1);
      rd(8'h10);
      check("mask_g0", got_rd[0], 24'hABCDC0);
      wr(8'h10, 24'hFFFFFF, 4'h0);
      rd(8'h10);
      check("mask_none", got_rd[0], 24'hABCDC0);

      wr(8'h20, 24'h111111, 4'hF);
      set_idle();
      w_en = 1'b1; w_addr = 8'h20; w_data = 24'hFFFFFF; w_mask = 4'h2;
      r_en = 1'b1; r_addr = 8'h20;
      tick();
      check("coll_bypass", got_rd[0], 24'h111FD1);
      check("coll_nobypass", got_rd[1], 24'h111111);
      check("coll_bypass_d200", got_rd[2], 24'h111FD1);
      rd(8'h20);
      check("after_coll_byp", got_rd[0], 24'h111FD1);
      check("after_coll_nobyp", got_rd[1], 24'h111FD1);

      // Out-of-range on the DEPTH=200 instance.
      set_idle();
      w_en = 1'b1; w_addr = 8'd210; w_data = 24'h5A5A5A; w_mask = 4'hF;
      r_en = 1'b1; r_addr = 8'd210;
      tick();
      check("oor_data", got_rd[2], 24'h000000);
      check("oor_valid", got_rv[2], 1'b1);

      repeat (1500) begin
         rand_inputs();
         tick();
      end

      for (int a = 0; a < 256; a++) rd(8'(a));

      // Reset in the middle of the clear sequence with a write held high.
      hold_reset(2);
      set_idle();
      w_en = 1'b1; w_addr = 8'd5; w_data = 24'hC3C3C3; w_mask = 4'hF;
      r_en = 1'b1; r_addr = 8'd5;
      repeat (100) tick();
      hold_reset(3);
      repeat (256) tick();
      check("reinit_done", got_done[0], 1'b1);
      rd(8'd5);
      check("reinit_entry5", got_rd[0], 24'h000000);
      check("reinit_entry5_nb", got_rd[1], 24'h000000);
      check("reinit_valid", got_rv[0], 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sram_array_1r1w.md
# sram_array_1r1w

Parametrised single-clock 1R1W memory array with per-group write masks, a registered read port, optional write-to-read forwarding and an optional clear-on-reset sequencer. It generalises the fixed-size masked-array models emitted for frontend/backend tables. It is the array primitive that predictor, TLB and tag tables instantiate when they need a defined post-reset state and deterministic read-during-write behaviour.

## Interface
- DATA_WIDTH, 24, data bits per entry.
- DEPTH, 256, number of entries; need not be a power of two.
- MASK_WIDTH, 4, write-mask groups. DATA_WIDTH % MASK_WIDTH == 0. Group g covers bits [(g+1)*G-1 : g*G], where G = DATA_WIDTH/MASK_WIDTH.
- BYPASS, 1. 1 = same-cycle write is forwarded to the read; 0 = read returns old data.
- INIT_ON_RESET, 1. 1 = clear the array after reset; 0 = no clear.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every entry during init.
- ADDR_WIDTH, derived, max(1, $clog2(DEPTH)); not overridable.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- w_en  in  1  write request.
- w_addr  in  ADDR_WIDTH  write index.
- w_data  in  DATA_WIDTH  write data.
- w_mask  in  MASK_WIDTH  per-group write enable.
- r_en  in  1  read request.
- r_addr  in  ADDR_WIDTH  read index.
- r_data  out  DATA_WIDTH  registered read data.
- r_valid  out  1  one-cycle pulse; r_data is updated in that cycle.
- init_done  out  1  array ready; requests are accepted only while this is high.

## Operation
- FSM states: INIT and RUN. Reset drives the FSM to INIT and clears the init counter to 0.
- INIT (INIT_ON_RESET=1):
  - Each cycle, write INIT_VALUE to entry cnt with all groups enabled, then increment cnt.
  - When cnt == DEPTH-1 is written, go to RUN.
  - w_en and r_en are ignored. Nothing is written and r_valid stays 0.
- INIT_ON_RESET=0: INIT lasts exactly one cycle and writes nothing; array contents are undefined.
- RUN, write: when w_en is high, each group g with w_mask[g]=1 takes w_data's group g. Other groups are kept. w_mask=0 is a no-op.
- RUN, read: when r_en is high, r_data <= ram[r_addr] and r_valid <= 1. Otherwise r_valid <= 0 and r_data holds its last value.
- Collision (w_en, r_en, w_addr==r_addr in the same cycle):
  - BYPASS=1: r_data = the old entry with the masked groups replaced by w_data.
  - BYPASS=0: r_data = the old entry.
  - In both modes the array is updated.
- Out-of-range address (>= DEPTH):
  - Write is dropped.
  - Read returns 0 with r_valid=1.
- Reset asserted at any time, including mid-INIT: the FSM aborts immediately; on release, a full INIT starts from entry 0.

## Timing
- Reset values: r_data=0, r_valid=0, init_done=0, FSM=INIT, cnt=0.
- Edge numbering: edge 0 is the first rising edge with reset low.
- INIT duration:
  - INIT_ON_RESET=1: entry k is written at edge k. init_done rises after edge DEPTH-1, and the first request is accepted at edge DEPTH.
  - INIT_ON_RESET=0: init_done rises after edge 0.
- Read latency is 1 cycle: a request sampled at edge n gives r_data/r_valid valid after edge n, observable until edge n+1.
- Write latency is 1 cycle. A read at edge n+1 of an address written at edge n sees the new data in both BYPASS modes.
- Back-to-back reads and writes are sustained every cycle; there is no backpressure after init_done.

## Structure
- Package sram_array_pkg holds:
  - the state typedef (INIT, RUN);
  - the function mask_merge(old, new, mask, G), used for both the array write and the bypass path.
- Single module; no sub-module. The array is a plain reg array inferred as memory.
- Out-of-range checks are generated only when DEPTH != 2**ADDR_WIDTH.

## Test plan
All scenarios use the defaults (G=6) unless stated.
- Release reset, count edges -> init_done rises after exactly edge 255. A read of 0x7F then returns 0x000000 with r_valid for 1 cycle.
- Write 0x10 = 0xABCDEF with mask 0xF, then read 0x10 next cycle -> r_data=0xABCDEF. Hold r_en low for 3 cycles -> r_data stays 0xABCDEF and r_valid=0.
- Write 0x10 = 0x000000 with mask 0x1, then read -> 0xABCDC0. Write with mask 0x0 -> 0xABCDC0 unchanged.
- Entry 0x20 = 0x111111. Write 0xFFFFFF with mask 0x2 and read 0x20 in the same cycle:
  - BYPASS=1 -> 0x111FD1.
  - BYPASS=0 -> 0x111111.
  - A following read returns 0x111FD1 in both modes.
- Assert reset at edge 100 of INIT with w_en to addr 5 held high -> r_valid=0 and init_done=0 throughout. After release, init_done rises after edge 255 of the new count and entry 5 reads 0x000000.
- DEPTH=200: write addr 210 and read addr 210 -> r_data=0 with r_valid=1, and entries 0..199 are unchanged.
